calc_e_dispatch: RTL and testbench

- Round-robin scheduler that shares NUM_UNITS calc_e_buf energy units between one incoming stream of candidate sequences.
- Tags each issued sequence and returns results strictly in issue order, paired with their sequence.
- Tracks the lowest energy seen and counts retired results.
- Sits between the Wishbone register interface and the calc_e_buf instances, replacing per-unit software polling.

---
 rtl/calc_e_dispatch_if.sv | 53 +++++
 rtl/calc_e_dispatch.sv | 253 +++++++++++++++++++++++++
 tb/tb_calc_e_dispatch.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_e_dispatch_if.sv
// Signal bundle for calc_e_dispatch: issue stream, per-unit issue/result ports, retire stream and stats.
// i_thresh/o_hit/o_hit_count exist only when CALC_E_DISPATCH_THRESH_EN is defined.
interface calc_e_dispatch_if #(
   parameter int SEQ_WIDTH = 8,
   parameter int E_WIDTH   = 16,
   parameter int NUM_UNITS = 2
);
   logic                           i_clear;
   logic [SEQ_WIDTH-1:0]           i_seq;
   logic                           i_valid;
   logic                           o_ready;
   logic [NUM_UNITS*SEQ_WIDTH-1:0] o_u_seq;
   logic [NUM_UNITS-1:0]           o_u_valid;
   logic [NUM_UNITS-1:0]           i_u_ready;
   logic [NUM_UNITS*E_WIDTH-1:0]   i_u_e;
   logic [NUM_UNITS-1:0]           i_u_valid;
   logic [NUM_UNITS-1:0]           o_u_ready;
   logic [E_WIDTH-1:0]             o_e;
   logic [SEQ_WIDTH-1:0]           o_e_seq;
   logic                           o_valid;
   logic                           i_ready;
   logic [E_WIDTH-1:0]             o_best_e;
   logic [SEQ_WIDTH-1:0]           o_best_seq;
   logic                           o_best_valid;
   logic [31:0]                    o_count;
`ifdef CALC_E_DISPATCH_THRESH_EN
   logic [E_WIDTH-1:0]             i_thresh;
   logic                           o_hit;
   logic [15:0]                    o_hit_count;
`endif

   // Dispatcher side
   modport slave (
`ifdef CALC_E_DISPATCH_THRESH_EN
      input  i_thresh,
      output o_hit, o_hit_count,
`endif
      input  i_clear, i_seq, i_valid, i_u_ready, i_u_e, i_u_valid, i_ready,
      output o_ready, o_u_seq, o_u_valid, o_u_ready, o_e, o_e_seq, o_valid,
      output o_best_e, o_best_seq, o_best_valid, o_count
   );

   // Register-interface / unit side
   modport master (
`ifdef CALC_E_DISPATCH_THRESH_EN
      output i_thresh,
      input  o_hit, o_hit_count,
`endif
      output i_clear, i_seq, i_valid, i_u_ready, i_u_e, i_u_valid, i_ready,
      input  o_ready, o_u_seq, o_u_valid, o_u_ready, o_e, o_e_seq, o_valid,
      input  o_best_e, o_best_seq, o_best_valid, o_count
   );
endinterface

// File: rtl/calc_e_dispatch.sv
// Round-robin calc_e_buf dispatcher: in-order retire (unit result -> o_valid in 1 cycle, held while !i_ready),
// best-energy and retire count; CALC_E_DISPATCH_THRESH_EN adds the threshold hit pulse and counter.

module calc_e_dispatch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;

   assign head_dat = mem_q[rd_ptr_q];
   assign full     = (cnt_q == DEPTH_C);
   assign empty    = (cnt_q == '0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

module calc_e_dispatch #(
   parameter int SEQ_WIDTH = 8,
   parameter int E_WIDTH   = 16,
   parameter int NUM_UNITS = 2,
   parameter int TAG_DEPTH = 4
) (
   input logic              wb_clk_i,
   input logic              wb_rst_i,
   calc_e_dispatch_if.slave bus
);
   localparam int UW = $clog2(NUM_UNITS);
   localparam logic [UW-1:0] LAST_UNIT = UW'(NUM_UNITS - 1);

   logic [UW-1:0]        issue_ptr_q, issue_ptr_d;
   logic [UW-1:0]        retire_ptr_q, retire_ptr_d;
   logic [E_WIDTH-1:0]   o_e_q, o_e_d;
   logic [SEQ_WIDTH-1:0] o_e_seq_q, o_e_seq_d;
   logic                 o_valid_q, o_valid_d;
   logic [E_WIDTH-1:0]   best_e_q, best_e_d;
   logic [SEQ_WIDTH-1:0] best_seq_q, best_seq_d;
   logic                 best_valid_q, best_valid_d;
   logic [31:0]          count_q, count_d;
`ifdef CALC_E_DISPATCH_THRESH_EN
   logic                 hit_q, hit_d;
   logic [15:0]          hit_count_q, hit_count_d;
`endif

   logic [NUM_UNITS-1:0] tag_full, tag_empty, tag_push, tag_pop;
   logic [SEQ_WIDTH-1:0] tag_head [NUM_UNITS];
   logic [NUM_UNITS-1:0] u_valid_c, u_ready_c;
   logic                 ready_c, out_free, issue_hs, retire_hs;
   logic [E_WIDTH-1:0]   ret_e;
   logic [SEQ_WIDTH-1:0] ret_seq;

   // One tag FIFO per unit holds the sequences it still owes a result for.
   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_tag
      calc_e_dispatch_fifo #(.W(SEQ_WIDTH), .DEPTH(TAG_DEPTH)) u_tag (
         .clk      (wb_clk_i),
         .rst      (wb_rst_i),
         .clr      (bus.i_clear),
         .push     (tag_push[k]),
         .push_dat (bus.i_seq),
         .pop      (tag_pop[k]),
         .head_dat (tag_head[k]),
         .full     (tag_full[k]),
         .empty    (tag_empty[k])
      );
   end

   // Handshake outputs are forced low while reset is asserted.
   always_comb begin
      ready_c   = 1'b0;
      u_valid_c = '0;
      u_ready_c = '0;
      ret_e     = '0;
      ret_seq   = '0;
      out_free  = ~o_valid_q | bus.i_ready;
      if (!wb_rst_i) begin
         ready_c = bus.i_u_ready[issue_ptr_q] & ~tag_full[issue_ptr_q];
         for (int k = 0; k < NUM_UNITS; k++) begin
            u_valid_c[k] = bus.i_valid & (issue_ptr_q == UW'(k)) & ~tag_full[k];
            u_ready_c[k] = (retire_ptr_q == UW'(k)) & ~tag_empty[k] & out_free;
         end
      end
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (retire_ptr_q == UW'(k)) begin
            ret_e   = bus.i_u_e[k*E_WIDTH +: E_WIDTH];
            ret_seq = tag_head[k];
         end
      end
      tag_push  = u_valid_c & bus.i_u_ready;
      tag_pop   = u_ready_c & bus.i_u_valid;
      issue_hs  = bus.i_valid & ready_c;
      retire_hs = |tag_pop;
   end

   always_comb begin
      issue_ptr_d  = issue_ptr_q;
      retire_ptr_d = retire_ptr_q;
      o_e_d        = o_e_q;
      o_e_seq_d    = o_e_seq_q;
      o_valid_d    = o_valid_q;
      best_e_d     = best_e_q;
      best_seq_d   = best_seq_q;
      best_valid_d = best_valid_q;
      count_d      = count_q;
`ifdef CALC_E_DISPATCH_THRESH_EN
      hit_d        = 1'b0;
      hit_count_d  = hit_count_q;
`endif
      if (issue_hs) begin
         issue_ptr_d = (issue_ptr_q == LAST_UNIT) ? '0 : issue_ptr_q + 1'b1;
      end
      if (retire_hs) begin
         retire_ptr_d = (retire_ptr_q == LAST_UNIT) ? '0 : retire_ptr_q + 1'b1;
         o_e_d        = ret_e;
         o_e_seq_d    = ret_seq;
         o_valid_d    = 1'b1;
         count_d      = count_q + 32'd1;
         // Strict less-than keeps the earlier sequence on a tie.
         if (!best_valid_q || (ret_e < best_e_q)) begin
            best_e_d     = ret_e;
            best_seq_d   = ret_seq;
            best_valid_d = 1'b1;
         end
`ifdef CALC_E_DISPATCH_THRESH_EN
         if (ret_e <= bus.i_thresh) begin
            hit_d = 1'b1;
            if (hit_count_q != 16'hFFFF) begin
               hit_count_d = hit_count_q + 16'd1;
            end
         end
`endif
      end else if (bus.i_ready) begin
         o_valid_d = 1'b0;
      end
      if (bus.i_clear) begin
         issue_ptr_d  = '0;
         retire_ptr_d = '0;
         o_e_d        = '0;
         o_e_seq_d    = '0;
         o_valid_d    = 1'b0;
         best_e_d     = '0;
         best_seq_d   = '0;
         best_valid_d = 1'b0;
         count_d      = '0;
`ifdef CALC_E_DISPATCH_THRESH_EN
         hit_d        = 1'b0;
         hit_count_d  = '0;
`endif
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         issue_ptr_q  <= '0;
         retire_ptr_q <= '0;
         o_e_q        <= '0;
         o_e_seq_q    <= '0;
         o_valid_q    <= 1'b0;
         best_e_q     <= '0;
         best_seq_q   <= '0;
         best_valid_q <= 1'b0;
         count_q      <= '0;
`ifdef CALC_E_DISPATCH_THRESH_EN
         hit_q        <= 1'b0;
         hit_count_q  <= '0;
`endif
      end else begin
         issue_ptr_q  <= issue_ptr_d;
         retire_ptr_q <= retire_ptr_d;
         o_e_q        <= o_e_d;
         o_e_seq_q    <= o_e_seq_d;
         o_valid_q    <= o_valid_d;
         best_e_q     <= best_e_d;
         best_seq_q   <= best_seq_d;
         best_valid_q <= best_valid_d;
         count_q      <= count_d;
`ifdef CALC_E_DISPATCH_THRESH_EN
         hit_q        <= hit_d;
         hit_count_q  <= hit_count_d;
`endif
      end
   end

   assign bus.o_ready      = ready_c;
   assign bus.o_u_seq      = {NUM_UNITS{bus.i_seq}};
   assign bus.o_u_valid    = u_valid_c;
   assign bus.o_u_ready    = u_ready_c;
   assign bus.o_e          = o_e_q;
   assign bus.o_e_seq      = o_e_seq_q;
   assign bus.o_valid      = o_valid_q;
   assign bus.o_best_e     = best_e_q;
   assign bus.o_best_seq   = best_seq_q;
   assign bus.o_best_valid = best_valid_q;
   assign bus.o_count      = count_q;
`ifdef CALC_E_DISPATCH_THRESH_EN
   assign bus.o_hit        = hit_q;
   assign bus.o_hit_count  = hit_count_q;
`endif
endmodule

// File: tb/tb_calc_e_dispatch.sv
// Bench for calc_e_dispatch: behavioural unit models, in-order scoreboard, table of best-tracking vectors.
`timescale 1ns/1ps
module tb_calc_e_dispatch;
   localparam int SW = 8;
   localparam int EW = 16;
   localparam int NU = 2;
   localparam int TD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   calc_e_dispatch_if #(.SEQ_WIDTH(SW), .E_WIDTH(EW), .NUM_UNITS(NU)) bus ();
   calc_e_dispatch #(.SEQ_WIDTH(SW), .E_WIDTH(EW), .NUM_UNITS(NU), .TAG_DEPTH(TD)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   typedef struct { logic [SW-1:0] seq; logic [EW-1:0] e; int due; } ent_t;
   typedef struct { logic [SW-1:0] seq; logic [EW-1:0] e; } exp_t;
   typedef struct {
      logic [SW-1:0] seq; logic [EW-1:0] e;
      logic [EW-1:0] best_e; logic [SW-1:0] best_seq; logic hit;
   } row_t;

   ent_t          uq [NU][$];
   exp_t          sb [$];
   logic [SW-1:0] src [$];
   logic [EW-1:0] en_map [256];
   int            lat [NU];
   logic [NU-1:0] urdy;
   logic          out_rdy;
   int            cyc, mptr;
   int            errors, checks;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      for (int k = 0; k < NU; k++) uq[k].delete();
      sb.delete();
      src.delete();
      mptr = 0;
   endtask

   // Drive all inputs from the models, then let combinational outputs settle.
   task automatic settle();
      for (int k = 0; k < NU; k++) begin
         bus.i_u_valid[k]         = (uq[k].size() > 0) && (uq[k][0].due <= cyc);
         bus.i_u_e[k*EW +: EW]    = (uq[k].size() > 0) ? uq[k][0].e : '0;
      end
      bus.i_u_ready = urdy;
      bus.i_ready   = out_rdy;
      bus.i_valid   = (src.size() > 0);
      bus.i_seq     = (src.size() > 0) ? src[0] : '0;
      #1;
   endtask

   // Record the handshakes that complete at the coming edge, then clock.
   task automatic advance();
      ent_t n;
      exp_t x;
      if (bus.i_valid && bus.o_ready) begin
         chk("issue_unit", 64'(bus.o_u_valid), 64'(1) << mptr);
         n.seq = bus.i_seq; n.e = en_map[bus.i_seq]; n.due = cyc + lat[mptr];
         uq[mptr].push_back(n);
         x.seq = n.seq; x.e = n.e;
         sb.push_back(x);
         void'(src.pop_front());
         mptr = (mptr + 1) % NU;
      end
      for (int k = 0; k < NU; k++) begin
         if (bus.i_u_valid[k] && bus.o_u_ready[k] && uq[k].size() > 0) void'(uq[k].pop_front());
      end
      if (bus.o_valid && bus.i_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got seq 0x%0h, required no output", bus.o_e_seq);
         end else begin
            x = sb.pop_front();
            chk("sb_seq", 64'(bus.o_e_seq), 64'(x.seq));
            chk("sb_e", 64'(bus.o_e), 64'(x.e));
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((src.size() > 0 || sb.size() > 0) && n < budget) begin
         cycle();
         n++;
      end
      checks++;
      if (src.size() > 0 || sb.size() > 0) begin
         errors++;
         $display("FAIL %s: timeout, got %0d results pending, required 0", name, sb.size() + src.size());
      end
   endtask

   // Leaves the bench settled in the cycle where o_valid is first seen.
   task automatic wait_valid(input string name, input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         settle();
         if (bus.o_valid) begin
            ok = 1'b1;
            break;
         end
         advance();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: o_valid got 0 for %0d cycles, required 1", name, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation got no end, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t          tbl [7];
      ent_t          t;
      bit            ok;
      logic [EW-1:0] held_e;
      logic [SW-1:0] held_seq;
      int            n;

      tbl[0] = '{8'hA1, 16'd40,     16'd40, 8'hA1, 1'b0};
      tbl[1] = '{8'hA2, 16'd12,     16'd12, 8'hA2, 1'b1};
      tbl[2] = '{8'hA3, 16'd12,     16'd12, 8'hA2, 1'b1};
      tbl[3] = '{8'hA4, 16'd30,     16'd12, 8'hA2, 1'b0};
      tbl[4] = '{8'hB0, 16'd20,     16'd12, 8'hA2, 1'b1};
      tbl[5] = '{8'hB1, 16'd0,      16'd0,  8'hB1, 1'b1};
      tbl[6] = '{8'hB2, 16'hFFFF,   16'd0,  8'hB1, 1'b0};

      errors = 0; checks = 0; cyc = 0;
      for (int s = 0; s < 256; s++) en_map[s] = 16'(s * 7 + 100);
      for (int k = 0; k < NU; k++) lat[k] = 1;
      urdy = '1; out_rdy = 1'b1;
      bus.i_clear = 1'b0; bus.i_valid = 1'b0; bus.i_seq = '0;
      bus.i_u_ready = '1; bus.i_u_valid = '0; bus.i_u_e = '0; bus.i_ready = 1'b1;
`ifdef CALC_E_DISPATCH_THRESH_EN
      bus.i_thresh = 16'd20;
`endif
      reset_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset in the middle of live traffic.
      for (int i = 1; i <= 4; i++) src.push_back(8'(i));
      repeat (3) cycle();
      settle();
      #2 rst = 1'b1;
      #1;
      chk("rst_o_valid", 64'(bus.o_valid), 0);
      chk("rst_o_e", 64'(bus.o_e), 0);
      chk("rst_o_e_seq", 64'(bus.o_e_seq), 0);
      chk("rst_o_count", 64'(bus.o_count), 0);
      chk("rst_best", 64'({bus.o_best_valid, bus.o_best_e, bus.o_best_seq}), 0);
      chk("rst_o_ready", 64'(bus.o_ready), 0);
      chk("rst_o_u_valid", 64'(bus.o_u_valid), 0);
      chk("rst_o_u_ready", 64'(bus.o_u_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      urdy = 2'b10;
      settle();
      chk("ready_after_rst_u0_busy", 64'(bus.o_ready), 0);
      urdy = 2'b01;
      settle();
      chk("ready_after_rst_u0_ready", 64'(bus.o_ready), 1);
      urdy = '1;
      advance();

      // Ordering: unit1 fast, unit0 slow.
      lat[0] = 6; lat[1] = 1;
      for (int i = 0; i < 4; i++) src.push_back(8'(8'h10 + i));
      drain("order_drain", 60);
      chk("order_count", 64'(bus.o_count), 4);

      // Backpressure on the retire port.
      lat[0] = 1; lat[1] = 1;
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) src.push_back(8'(8'h20 + i));
      wait_valid("bp_first", 20, ok);
      if (ok) begin
         held_e = bus.o_e; held_seq = bus.o_e_seq;
         chk("bp_first_seq", 64'(held_seq), 64'h20);
         advance();
         for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_hold_e", 64'(bus.o_e), 64'(held_e));
            chk("bp_hold_seq", 64'(bus.o_e_seq), 64'(held_seq));
            chk("bp_u_ready", 64'(bus.o_u_ready), 0);
            advance();
         end
         out_rdy = 1'b1;
         cycle();
         settle();
         chk("bp_next_valid", 64'(bus.o_valid), 1);
         chk("bp_next_seq", 64'(bus.o_e_seq), 64'h21);
         advance();
      end
      out_rdy = 1'b1;
      drain("bp_drain", 60);

      // Tag full: unit0 holds its results.
      lat[0] = 1000; lat[1] = 1;
      for (int i = 0; i < 9; i++) src.push_back(8'(8'h30 + i));
      n = 0;
      while (src.size() > 1 && n < 40) begin cycle(); n++; end
      chk("full_issued", 64'(src.size()), 1);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("full_blocks", 64'(bus.o_ready), 0);
         advance();
      end
      if (uq[0].size() > 0) begin
         t = uq[0][0]; t.due = cyc; uq[0][0] = t;
      end
      settle();
      chk("full_pop_cycle_ready", 64'(bus.o_ready), 0);
      chk("full_pop_u0_ready", 64'(bus.o_u_ready[0]), 1);
      advance();
      settle();
      chk("full_restored", 64'(bus.o_ready), 1);
      advance();
      lat[0] = 1;
      for (int i = 0; i < uq[0].size(); i++) begin
         t = uq[0][i]; t.due = cyc; uq[0][i] = t;
      end
      drain("full_drain", 100);

      // Synchronous clear with three results in flight.
      lat[0] = 1000; lat[1] = 1000;
      for (int i = 0; i < 3; i++) src.push_back(8'(8'h40 + i));
      n = 0;
      while (src.size() > 0 && n < 20) begin cycle(); n++; end
      bus.i_clear = 1'b1;
      settle();
      advance();
      bus.i_clear = 1'b0;
      reset_model();
      lat[0] = 1; lat[1] = 1;
      settle();
      chk("clr_count", 64'(bus.o_count), 0);
      chk("clr_best", 64'({bus.o_best_valid, bus.o_best_e, bus.o_best_seq}), 0);
      chk("clr_o_valid", 64'(bus.o_valid), 0);
      chk("clr_u_ready", 64'(bus.o_u_ready), 0);
`ifdef CALC_E_DISPATCH_THRESH_EN
      chk("clr_hit_count", 64'(bus.o_hit_count), 0);
`endif
      src.push_back(8'h43);
      settle();
      chk("clr_issue_ptr", 64'(bus.o_u_valid), 64'b01);
      advance();
      drain("clr_drain", 20);
      chk("first_best_e", 64'(bus.o_best_e), 64'(en_map[8'h43]));

      // Best tracking and threshold table.
      for (int i = 0; i < 7; i++) begin
         en_map[tbl[i].seq] = tbl[i].e;
         src.push_back(tbl[i].seq);
         wait_valid("tbl_wait", 20, ok);
         if (ok) begin
            chk("tbl_seq", 64'(bus.o_e_seq), 64'(tbl[i].seq));
            chk("tbl_e", 64'(bus.o_e), 64'(tbl[i].e));
            chk("tbl_best_e", 64'(bus.o_best_e), 64'(tbl[i].best_e));
            chk("tbl_best_seq", 64'(bus.o_best_seq), 64'(tbl[i].best_seq));
            chk("tbl_best_valid", 64'(bus.o_best_valid), 1);
`ifdef CALC_E_DISPATCH_THRESH_EN
            chk("tbl_hit", 64'(bus.o_hit), 64'(tbl[i].hit));
`endif
            advance();
         end
      end
      drain("tbl_drain", 20);
      chk("tbl_count", 64'(bus.o_count), 8);
`ifdef CALC_E_DISPATCH_THRESH_EN
      chk("tbl_hit_count", 64'(bus.o_hit_count), 4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
